// File: rtl/rdcntrl_gen_pkg.sv
// Shared types and helpers for the CFEB readout-control block.
package rdcntrl_gen_pkg;

    // Descriptor push FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } push_state_t;

    // Width-independent part of a readout descriptor; the parametrised
    // block address and position vector are wrapped around it in the top.
    typedef struct packed {
        logic scnd;   // continuation of a trigger from an earlier block
        logic shr;    // block also carries a new match of its own
    } desc_flags_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rdcntrl_gen_fifo.sv
// First-word-fall-through FIFO with full/empty flags. The head word is
// visible the cycle after it is written; a pop on an empty FIFO is ignored
// and a push while full is only accepted when a pop frees a slot the same
// cycle. dout reads as zero while empty so the outputs are clean at reset.
module rdcntrl_fifo
    import rdcntrl_gen_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] mem_reg [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write; contents need no reset because dout is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rdcntrl_gen.sv
// Readout control: matches delayed LCTs against L1A inside a programmable
// window, tracks per-block match history and queues readout descriptors and
// L1A numbers for the readout sequencer.
module rdcntrl_gen
    import rdcntrl_gen_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BLK_W  = 4,
    parameter int NPOS   = 8,
    parameter int L1AN_W = 6,
    parameter int NSHR   = 2,
    parameter int DLY_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lct,
    input  logic              l1a,
    input  logic [DLY_W-1:0]  lct_dly,
    input  logic [1:0]        win,
    input  logic              blk_end,
    input  logic [BLK_W-1:0]  blk_id,
    input  logic              slot_adv,
    input  logic              rd_pop,
    input  logic              l1an_pop,
    output logic              dav,
    output logic              nomatch,
    output logic              desc_empty,
    output logic              desc_full,
    output logic [BLK_W-1:0]  desc_blk,
    output logic [NPOS-1:0]   desc_pos,
    output logic              desc_scnd,
    output logic              desc_shr,
    output logic              l1an_empty,
    output logic [L1AN_W-1:0] l1anum,
    output logic              ovf,
    output logic [7:0]        ovf_cnt
);
    localparam int DLY_N  = 1 << DLY_W;
    localparam int SLOT_W = (NPOS > 1) ? clog2(NPOS) : 1;

    typedef struct packed {
        logic [BLK_W-1:0] blk;
        logic [NPOS-1:0]  pos;
        desc_flags_t      flags;
    } desc_t;

    logic [DLY_N-1:0]  dly_line_reg;
    logic [2:0]        win_cnt_reg;
    logic              dav_reg;
    logic              nomatch_reg;
    logic [L1AN_W-1:0] l1a_cnt_reg;
    logic [L1AN_W-1:0] l1an_cap_reg;
    logic [SLOT_W-1:0] slot_reg;
    logic [NPOS-1:0]   pos_reg;
    logic [NSHR-1:0]   hist_reg;
    desc_t             desc_lat_reg;
    push_state_t       state_reg, state_next;
    logic              ovf_reg;
    logic [7:0]        ovf_cnt_reg;

    logic              lct_hit;
    logic              win_open;
    logic              match;
    logic              win_last;
    logic [NSHR-1:0]   hist_eff;
    logic              any_h;
    logic [NPOS-1:0]   pos_eff;
    logic              need_push;
    logic              desc_push;
    logic              desc_drop;
    logic              l1an_full;
    logic              l1an_drop;
    desc_t             desc_head;
    logic [$bits(desc_t)-1:0] desc_dout;

    // Delayed LCT: tap k is the LCT seen k+1 cycles ago, so 0 means next cycle.
    assign lct_hit  = dly_line_reg[lct_dly];
    // win_cnt_reg counts open cycles still to come after the current one.
    assign win_open = lct_hit | (win_cnt_reg != 3'd0);
    assign match    = win_open & l1a;
    assign win_last = win_open & ~l1a &
                      (lct_hit ? (win == 2'd0) : (win_cnt_reg == 3'd1));

    // A DAV in the cycle of BLK_END still belongs to the ending block.
    assign hist_eff  = hist_reg | NSHR'(dav_reg);
    assign any_h     = |(hist_reg >> 1);
    assign pos_eff   = pos_reg | (dav_reg ? (NPOS'(1) << slot_reg) : '0);
    assign need_push = (hist_eff != '0);

    // LCT delay line and match window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_line_reg <= '0;
            win_cnt_reg  <= '0;
            dav_reg      <= 1'b0;
            nomatch_reg  <= 1'b0;
        end else begin
            dly_line_reg <= {dly_line_reg[DLY_N-2:0], lct};
            if (match)                    win_cnt_reg <= '0;
            else if (lct_hit)             win_cnt_reg <= {1'b0, win};
            else if (win_cnt_reg != 3'd0) win_cnt_reg <= win_cnt_reg - 3'd1;
            dav_reg     <= match;
            nomatch_reg <= win_last;
        end
    end

    // L1A counter and capture of the count belonging to the matched L1A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1a_cnt_reg  <= '0;
            l1an_cap_reg <= '0;
        end else begin
            if (l1a)   l1a_cnt_reg  <= l1a_cnt_reg + L1AN_W'(1);
            if (match) l1an_cap_reg <= l1a_cnt_reg;
        end
    end

    // Per-block slot, position vector and match history; descriptor latch at block end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg     <= '0;
            pos_reg      <= '0;
            hist_reg     <= '0;
            desc_lat_reg <= '0;
        end else if (blk_end) begin
            slot_reg                 <= '0;
            pos_reg                  <= '0;
            hist_reg                 <= hist_eff << 1;
            desc_lat_reg.blk         <= blk_id;
            desc_lat_reg.pos         <= pos_eff;
            desc_lat_reg.flags.scnd  <= any_h;
            desc_lat_reg.flags.shr   <= hist_eff[0] & any_h;
        end else begin
            if (slot_adv) begin
                slot_reg <= (slot_reg == SLOT_W'(NPOS - 1)) ? '0 : slot_reg + SLOT_W'(1);
            end
            pos_reg  <= pos_eff;
            hist_reg <= hist_eff;
        end
    end

    // Push FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Push FSM next state; COMMIT is the single push cycle.
    always_comb begin
        state_next = state_reg;
        desc_push  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (blk_end && need_push) state_next = ST_COMMIT;
                else if (need_push)       state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (blk_end) state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                desc_push = 1'b1;
                if (blk_end && need_push) state_next = ST_COMMIT;
                else if (need_push)       state_next = ST_ARMED;
                else                      state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A pop while full always succeeds, so it rescues the coincident push.
    assign desc_drop = desc_push & desc_full & ~rd_pop;
    assign l1an_drop = dav_reg & l1an_full & ~l1an_pop;

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg     <= 1'b0;
            ovf_cnt_reg <= '0;
        end else if (desc_drop || l1an_drop) begin
            ovf_reg <= 1'b1;
            if (ovf_cnt_reg != 8'hFF) ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
        end
    end

    rdcntrl_fifo #(.W($bits(desc_t)), .DEPTH(DEPTH)) u_desc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (desc_push),
        .din   (desc_lat_reg),
        .pop   (rd_pop),
        .dout  (desc_dout),
        .empty (desc_empty),
        .full  (desc_full)
    );

    rdcntrl_fifo #(.W(L1AN_W), .DEPTH(DEPTH)) u_l1an_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dav_reg),
        .din   (l1an_cap_reg),
        .pop   (l1an_pop),
        .dout  (l1anum),
        .empty (l1an_empty),
        .full  (l1an_full)
    );

    assign desc_head = desc_dout;
    assign desc_blk  = desc_head.blk;
    assign desc_pos  = desc_head.pos;
    assign desc_scnd = desc_head.flags.scnd;
    assign desc_shr  = desc_head.flags.shr;
    assign dav       = dav_reg;
    assign nomatch   = nomatch_reg;
    assign ovf       = ovf_reg;
    assign ovf_cnt   = ovf_cnt_reg;

endmodule

// File: tb/tb_rdcntrl_gen.sv
// Directed bench for rdcntrl_gen: window match/no-match, descriptor history,
// FIFO full/overflow, pop-while-full and asynchronous reset mid-block.
module tb_rdcntrl_gen;

    logic       clk;
    logic       rst_n;
    logic       lct;
    logic       l1a;
    logic [3:0] lct_dly;
    logic [1:0] win;
    logic       blk_end;
    logic [3:0] blk_id;
    logic       slot_adv;
    logic       rd_pop;
    logic       l1an_pop;
    logic       dav;
    logic       nomatch;
    logic       desc_empty;
    logic       desc_full;
    logic [3:0] desc_blk;
    logic [7:0] desc_pos;
    logic       desc_scnd;
    logic       desc_shr;
    logic       l1an_empty;
    logic [5:0] l1anum;
    logic       ovf;
    logic [7:0] ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rdcntrl_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lct        (lct),
        .l1a        (l1a),
        .lct_dly    (lct_dly),
        .win        (win),
        .blk_end    (blk_end),
        .blk_id     (blk_id),
        .slot_adv   (slot_adv),
        .rd_pop     (rd_pop),
        .l1an_pop   (l1an_pop),
        .dav        (dav),
        .nomatch    (nomatch),
        .desc_empty (desc_empty),
        .desc_full  (desc_full),
        .desc_blk   (desc_blk),
        .desc_pos   (desc_pos),
        .desc_scnd  (desc_scnd),
        .desc_shr   (desc_shr),
        .l1an_empty (l1an_empty),
        .l1anum     (l1anum),
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // LCT in cycle t0, L1A in t0+4 (inside the window for LCT_DLY=3);
    // returns in t0+5 after checking the DAV pulse.
    task automatic do_match(input string tag);
        lct = 1'b1; tick(); lct = 1'b0;
        tick(); tick(); tick();
        check({tag, "_dav_before"}, dav, 1'b0);
        l1a = 1'b1; tick(); l1a = 1'b0;
        check({tag, "_dav"}, dav, 1'b1);
    endtask

    task automatic end_block(input logic [3:0] id);
        blk_end = 1'b1; blk_id = id; tick(); blk_end = 1'b0;
        tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; lct = 1'b0; l1a = 1'b0; lct_dly = 4'd3; win = 2'd1;
        blk_end = 1'b0; blk_id = 4'd0; slot_adv = 1'b0; rd_pop = 1'b0; l1an_pop = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_desc_empty", desc_empty, 1'b1);
        check("rst_l1an_empty", l1an_empty, 1'b1);
        check("rst_desc_full", desc_full, 1'b0);
        check("rst_dav", dav, 1'b0);
        check("rst_nomatch", nomatch, 1'b0);
        check("rst_desc_blk", desc_blk, 4'd0);
        check("rst_l1anum", l1anum, 6'd0);
        check("rst_ovf_cnt", {ovf, ovf_cnt}, 9'd0);
        rst_n = 1'b1; tick();

        // Match in block 5 at slot 2, then two block ends
        slot_adv = 1'b1; tick(); tick(); slot_adv = 1'b0;
        do_match("m1");
        tick();
        check("m1_dav_pulse", dav, 1'b0);
        check("m1_no_nomatch", nomatch, 1'b0);
        check("m1_l1an_empty", l1an_empty, 1'b0);
        check("m1_l1anum", l1anum, 6'd0);
        end_block(4'd5);
        check("b5_not_empty", desc_empty, 1'b0);
        check("b5_blk", desc_blk, 4'd5);
        check("b5_pos", desc_pos, 8'h04);
        check("b5_scnd", desc_scnd, 1'b0);
        check("b5_shr", desc_shr, 1'b0);
        check("b5_l1anum", l1anum, 6'd0);
        end_block(4'd6);
        rd_pop = 1'b1; l1an_pop = 1'b1; tick(); rd_pop = 1'b0; l1an_pop = 1'b0;
        check("b6_blk", desc_blk, 4'd6);
        check("b6_pos", desc_pos, 8'h00);
        check("b6_scnd", desc_scnd, 1'b1);
        check("b6_shr", desc_shr, 1'b0);
        check("l1an_popped", l1an_empty, 1'b1);
        rd_pop = 1'b1; tick(); rd_pop = 1'b0;
        check("b6_popped", desc_empty, 1'b1);

        // LCT without L1A: NOMATCH in t0+6 only
        lct = 1'b1; tick(); lct = 1'b0;
        tick(); tick(); tick(); tick();
        check("nm_t5", nomatch, 1'b0);
        tick();
        check("nm_t6", nomatch, 1'b1);
        check("nm_no_dav", dav, 1'b0);
        tick();
        check("nm_t7", nomatch, 1'b0);
        // Stray L1A outside any window still counts
        l1a = 1'b1; tick(); l1a = 1'b0; tick();
        check("stray_no_dav", dav, 1'b0);
        end_block(4'd7);
        tick();
        check("nm_desc_empty", desc_empty, 1'b1);
        check("nm_l1an_empty", l1an_empty, 1'b1);

        // Five matched blocks 8..12 with no RD_POP: fifth descriptor dropped
        for (int i = 0; i < 5; i++) begin
            do_match("fill");
            tick();
            check("fill_l1anum", l1anum, 32'(2 + i));
            l1an_pop = 1'b1; tick(); l1an_pop = 1'b0;
            end_block(4'(8 + i));
            if (i == 3) begin
                check("fill4_full", desc_full, 1'b1);
                check("fill4_ovf", ovf, 1'b0);
            end
        end
        check("ovf_set", ovf, 1'b1);
        check("ovf_cnt1", ovf_cnt, 8'd1);
        check("full_head_blk", desc_blk, 4'd8);
        check("full_still", desc_full, 1'b1);

        // Continuation block 13 committed while RD_POP frees the head
        blk_end = 1'b1; blk_id = 4'd13; tick(); blk_end = 1'b0;
        rd_pop = 1'b1; tick(); rd_pop = 1'b0;
        tick();
        check("pp_full", desc_full, 1'b1);
        check("pp_ovf_cnt", ovf_cnt, 8'd1);
        check("pp_head_blk", desc_blk, 4'd9);
        check("pp_head_pos", desc_pos, 8'h01);
        check("pp_head_scnd", desc_scnd, 1'b1);
        check("pp_head_shr", desc_shr, 1'b1);
        rd_pop = 1'b1; tick(); tick(); tick(); rd_pop = 1'b0;
        check("b13_blk", desc_blk, 4'd13);
        check("b13_scnd", desc_scnd, 1'b1);
        check("b13_shr", desc_shr, 1'b0);
        rd_pop = 1'b1; tick(); tick(); rd_pop = 1'b0;
        check("drain_empty", desc_empty, 1'b1);
        check("drain_not_full", desc_full, 1'b0);

        // Asynchronous reset while ARMED with queued data
        do_match("r1");
        tick();
        end_block(4'd2);
        do_match("r2");
        tick();
        check("pre_rst_desc", desc_empty, 1'b0);
        check("pre_rst_l1an", l1an_empty, 1'b0);
        rst_n = 1'b0; #1;
        check("arst_desc_empty", desc_empty, 1'b1);
        check("arst_l1an_empty", l1an_empty, 1'b1);
        check("arst_ovf", {ovf, ovf_cnt}, 9'd0);
        check("arst_desc_blk", desc_blk, 4'd0);
        tick(); rst_n = 1'b1; tick();
        end_block(4'd3);
        tick();
        check("post_rst_no_push", desc_empty, 1'b1);
        check("post_rst_no_l1an", l1an_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rdcntrl_gen.md
Name: rdcntrl_gen

Overview:
- Parametrised readout-control block for the CFEB SCA path.
- Classifies each delayed LCT against the global L1A inside a programmable match window.
- Accumulates per-block match / no-match flags and an L1A position vector across a configurable number of shared blocks.
- Queues readout descriptors and L1A numbers in depth-parametrised FIFOs for the readout sequencer, with overflow counting that the fixed-depth generation lacks.

Parameters:
- DEPTH, 4, descriptor and L1A-number FIFO depth; power of 2, 2..16.
- BLK_W, 4, SCA block address width.
- NPOS, 8, L1A position vector width (sub-block time slots).
- L1AN_W, 6, L1A counter width.
- NSHR, 2, blocks a single trigger may span (history stages); 1..4.
- DLY_W, 4, LCT delay setting width.

Ports:
- CLK in 1 system clock, all logic rising-edge.
- RST_N in 1 asynchronous, active-low reset.
- LCT in 1 LCT strobe, one cycle per LCT.
- L1A in 1 global L1A strobe.
- LCT_DLY in DLY_W LCT delay in cycles before window opens.
- WIN in 2 window width: window = WIN+1 cycles.
- BLK_END in 1 one-cycle pulse, end of current capture block.
- BLK_ID in BLK_W address of block now ending.
- SLOT_ADV in 1 advance position slot, pulse.
- RD_POP in 1 sequencer done with head descriptor.
- L1AN_POP in 1 pop head L1A number.
- DAV out 1 one-cycle pulse, L1A matched an open window.
- NOMATCH out 1 one-cycle pulse, window expired without L1A.
- DESC_EMPTY out 1 descriptor FIFO empty.
- DESC_FULL out 1 descriptor FIFO full.
- DESC_BLK out BLK_W head block address.
- DESC_POS out NPOS head L1A position vector.
- DESC_SCND out 1 head is a continuation block.
- DESC_SHR out 1 head block shared by two triggers.
- L1AN_EMPTY out 1 L1A-number FIFO empty.
- L1ANUM out L1AN_W head L1A number.
- OVF out 1 sticky: a push was dropped.
- OVF_CNT out 8 dropped pushes, saturating at 255.

Behaviour:
- Reset (RST_N low, async): all FIFOs empty; DESC_EMPTY=1, L1AN_EMPTY=1; every other output 0; L1A counter 0; FSM IDLE. Reset mid-block discards in-flight flags; no partial push.
- LCT delay: LCT delayed by LCT_DLY cycles (0 means next cycle) opens a window of WIN+1 cycles.
- Overlapping windows: a new delayed LCT while a window is open restarts the window length.
- DAV: L1A while the window is open gives DAV on the next cycle and closes the window.
- NOMATCH: window expiry without L1A gives NOMATCH on the cycle after the last window cycle.
- L1A counter: increments on every L1A, wraps modulo 2^L1AN_W.
- L1A-number FIFO: on DAV, counter value captured at that L1A is pushed.
- Per block: match flag m0 sets on DAV and clears at BLK_END; position vector bit [slot] sets on DAV.
- Slot counter: advanced by SLOT_ADV, wraps at NPOS-1, reset to 0 at BLK_END.
- History: at BLK_END, history shifts m0 -> h[1] .. h[NSHR-1].
- Push FSM states: IDLE, ARMED, COMMIT.
  - IDLE -> ARMED when m0 sets or any h set.
  - ARMED -> COMMIT on BLK_END.
  - COMMIT lasts 1 cycle: pushes {BLK_ID, pos, SCND = any h[k>=1] set at push, SHR = m0 & any h}, then -> ARMED if history nonzero, else IDLE.
  - DAV coincident with BLK_END belongs to the ending block.
- Full handling: push while full (either FIFO) is dropped; OVF sets, OVF_CNT increments.
- Pop rules: RD_POP or L1AN_POP on an empty FIFO is ignored. Simultaneous push and pop while full is accepted (pop first); while empty, the head appears the following cycle.
- FIFO latency: first-word-fall-through; head valid the cycle after push.
- Pointers: BLK_W-independent, log2(DEPTH)+1 bits, wrap naturally.

Decomposition:
- Shared package: descriptor struct {blk, pos, scnd, shr}, FSM state enum, function clog2.
- One sub-module: rdcntrl_fifo (parametrised width/depth, FWFT, full/empty), instantiated twice.

Test Plan:
- LCT_DLY=3, WIN=1; LCT at t0, L1A at t0+4 -> DAV at t0+5; L1ANUM=0 after BLK_END commit.
- LCT_DLY=3, WIN=1; LCT only -> NOMATCH at t0+6; no descriptor pushed; DESC_EMPTY stays 1.
- DAV in block 5 then BLK_END, BLK_END (NSHR=2) -> descriptors blk5 scnd=0 and blk6 scnd=1; DESC_POS bit set at matched slot.
- DEPTH=4: five matched blocks without RD_POP -> DESC_FULL after 4; OVF=1, OVF_CNT=1; head still the first block.
- RD_POP while full, coincident with commit -> accepted; count stays 4, OVF_CNT unchanged.
- RST_N low mid-ARMED -> immediately empty and IDLE; next block pushes nothing unless a new DAV occurs.
